img_byte_writer: RTL and testbench



---
 rtl/img_byte_writer.sv | 115 +++++++++++
 tb/tb_img_byte_writer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/img_byte_writer.sv
// Host-link byte packer: waits for a frame sync byte, assembles R,G,B triplets
// into pixels and writes them to the frame RAM at consecutive addresses.
//
// state   | meaning
// --------+------------------------------------------------------------------
// IDLE    | waiting for the sync byte; all other bytes ignored
// RECV    | collecting R,G,B bytes; one RAM write per completed pixel
// DONE    | final pixel written; one cycle, raises frame_done, bytes dropped
module img_byte_writer #(
  parameter int                    RGB_WIDTH  = 24,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    IMG_WIDTH  = 80,
  parameter int                    IMG_HEIGHT = 120,
  parameter int                    ADDR_WIDTH = $clog2(IMG_WIDTH*IMG_HEIGHT),
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE  = 8'hAA
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  input  logic                  abort,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [RGB_WIDTH-1:0]  wdata,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int unsigned           NUM_PIX  = IMG_WIDTH * IMG_HEIGHT;
  localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(NUM_PIX - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RECV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] PH_R = 2'd0;
  localparam logic [1:0] PH_G = 2'd1;

  logic [1:0]            state;
  logic [1:0]            byte_phase;
  logic [ADDR_WIDTH-1:0] pix_cnt;
  logic [DATA_WIDTH-1:0] r_hold;
  logic [DATA_WIDTH-1:0] g_hold;

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      byte_phase <= PH_R;
      pix_cnt    <= '0;
      r_hold     <= '0;
      g_hold     <= '0;
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      frame_done <= 1'b0;
    end else begin
      // Strobes default low; waddr/wdata hold between writes.
      we         <= 1'b0;
      frame_done <= 1'b0;
      if (abort) begin
        // Partial pixel is dropped by clearing the phase; RAM keeps what was written.
        state      <= ST_IDLE;
        byte_phase <= PH_R;
        pix_cnt    <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (rx_valid && (rx_data == SYNC_BYTE)) begin
              state      <= ST_RECV;
              byte_phase <= PH_R;
              pix_cnt    <= '0;
            end
          end
          ST_RECV: begin
            if (rx_valid) begin
              case (byte_phase)
                PH_R: begin
                  r_hold     <= rx_data;
                  byte_phase <= PH_G;
                end
                PH_G: begin
                  g_hold     <= rx_data;
                  byte_phase <= 2'd2;
                end
                default: begin
                  byte_phase <= PH_R;
                  we         <= 1'b1;
                  waddr      <= pix_cnt;
                  wdata      <= {r_hold, g_hold, rx_data};
                  if (pix_cnt == LAST_PIX) begin
                    pix_cnt <= '0;
                    state   <= ST_DONE;
                  end else begin
                    pix_cnt <= pix_cnt + ADDR_WIDTH'(1);
                  end
                end
              endcase
            end
          end
          ST_DONE: begin
            frame_done <= 1'b1;
            state      <= ST_IDLE;
          end
          default: begin
            state      <= ST_IDLE;
            byte_phase <= PH_R;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_img_byte_writer.sv
// Directed bench for img_byte_writer: sync detect, pixel packing, full frames
// with and without gaps, abort, and byte drop in the DONE cycle.
module tb_img_byte_writer;

  localparam int NPIX = 9600;
  localparam int AW   = 14;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          abort;
  logic          we;
  logic [AW-1:0] waddr;
  logic [23:0]   wdata;
  logic          frame_done;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  img_byte_writer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .abort      (abort),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
  endtask

  function automatic logic [7:0] pix_byte(input int p, input int k);
    logic [7:0] lo;
    lo = p[7:0];
    case (k)
      0:       return lo;
      1:       return ~lo;
      default: return 8'h5A;
    endcase
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    abort   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rx_valid = 1'($urandom_range(0, 1));
      rx_data  = (i == 0) ? 8'hAA : 8'($urandom);
      @(posedge clk);
      #1;
      n_cmp++;
      if ({we, frame_done, busy} !== 3'b000 || waddr !== '0 || wdata !== '0) begin
        n_bad++;
        $display("FAIL reset_outputs cyc%0d: we=%b fd=%b busy=%b waddr=%0d wdata=%h, need all 0",
                 i, we, frame_done, busy, waddr, wdata);
      end
    end
    rx_valid = 1'b0;
    reset_n  = 1'b1;
    idle_cycle();
    n_cmp++;
    if (busy !== 1'b0 || we !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: busy=%b we=%b, need 0 0", busy, we);
    end
  endtask

  task automatic test_idle_sync();
    send_byte(8'h12);
    send_byte(8'h55);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_ignore: busy=%b, need 0", busy);
    end
    send_byte(8'hAA);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL sync_busy: busy=%b, need 1", busy);
    end
    send_byte(8'h10);
    send_byte(8'h20);
    n_cmp++;
    if (we !== 1'b0) begin
      n_bad++;
      $display("FAIL early_we: we=%b, need 0", we);
    end
    send_byte(8'h30);
    n_cmp++;
    if (we !== 1'b1 || waddr !== 14'd0 || wdata !== 24'h102030) begin
      n_bad++;
      $display("FAIL first_pixel: we=%b waddr=%0d wdata=%h, need 1 0 102030", we, waddr, wdata);
    end
    idle_cycle();
    n_cmp++;
    if (we !== 1'b0 || waddr !== 14'd0 || wdata !== 24'h102030) begin
      n_bad++;
      $display("FAIL we_single: we=%b waddr=%0d wdata=%h, need 0 0 102030 (held)", we, waddr, wdata);
    end
    pulse_abort();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_idle: busy=%b, need 0", busy);
    end
  endtask

  // Streams one whole frame; returns in the DONE cycle (final we visible).
  task automatic test_full_frame(input bit with_gaps);
    int         bad;
    int         we_cnt;
    logic [7:0] lo;
    bad    = 0;
    we_cnt = 0;
    send_byte(8'hAA);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL frame_sync gaps=%0d: busy=%b, need 1", with_gaps, busy);
    end
    for (int p = 0; p < NPIX; p++) begin
      for (int k = 0; k < 3; k++) begin
        if (with_gaps && $urandom_range(0, 15) == 0) begin
          repeat ($urandom_range(1, 5)) begin
            idle_cycle();
            if (we !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b1) bad++;
          end
        end
        send_byte(pix_byte(p, k));
        if (k == 2) begin
          lo = p[7:0];
          if (we === 1'b1) we_cnt++;
          if (we !== 1'b1 || waddr !== AW'(p) || wdata !== {lo, ~lo, 8'h5A}) begin
            bad++;
            if (bad < 4)
              $display("pixel %0d: we=%b waddr=%0d wdata=%h", p, we, waddr, wdata);
          end
        end else if (we !== 1'b0) begin
          bad++;
        end
        if (frame_done !== 1'b0 || busy !== 1'b1) bad++;
      end
    end
    n_cmp++;
    if (we_cnt !== NPIX) begin
      n_bad++;
      $display("FAIL frame_we_count gaps=%0d: got %0d, need %0d", with_gaps, we_cnt, NPIX);
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL frame_contents gaps=%0d: %0d bad cycles, need 0", with_gaps, bad);
    end
  endtask

  task automatic check_frame_end(input string tag);
    n_cmp++;
    if (frame_done !== 1'b1 || busy !== 1'b0 || we !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_done: fd=%b busy=%b we=%b, need 1 0 0", tag, frame_done, busy, we);
    end
    idle_cycle();
    n_cmp++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_after: fd=%b busy=%b, need 0 0", tag, frame_done, busy);
    end
  endtask

  task automatic test_done_drop();
    send_byte(8'hAA);
    check_frame_end("b2b");
    send_byte(8'hAA);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL restart_sync: busy=%b, need 1", busy);
    end
    send_byte(8'h07);
    send_byte(8'h08);
    send_byte(8'h09);
    n_cmp++;
    if (we !== 1'b1 || waddr !== 14'd0 || wdata !== 24'h070809) begin
      n_bad++;
      $display("FAIL restart_pixel: we=%b waddr=%0d wdata=%h, need 1 0 070809", we, waddr, wdata);
    end
    pulse_abort();
  endtask

  task automatic test_gapped_frame();
    test_full_frame(1'b1);
    idle_cycle();
    check_frame_end("gap");
  endtask

  task automatic test_abort();
    int fd_seen;
    fd_seen = 0;
    send_byte(8'hAA);
    for (int i = 0; i < 12; i++) send_byte(8'h40 + 8'(i));
    n_cmp++;
    if (we !== 1'b1 || waddr !== 14'd3 || wdata !== 24'h494A4B) begin
      n_bad++;
      $display("FAIL abort_prewrite: we=%b waddr=%0d wdata=%h, need 1 3 494a4b", we, waddr, wdata);
    end
    send_byte(8'hEE);
    abort    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    @(posedge clk);
    #1;
    abort    = 1'b0;
    rx_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || we !== 1'b0 || frame_done !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_cycle: busy=%b we=%b fd=%b, need 0 0 0", busy, we, frame_done);
    end
    idle_cycle();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_sync_ignored: busy=%b, need 0", busy);
    end
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    n_cmp++;
    if (we !== 1'b1 || waddr !== 14'd0 || wdata !== 24'h010203) begin
      n_bad++;
      $display("FAIL abort_new_pixel: we=%b waddr=%0d wdata=%h, need 1 0 010203", we, waddr, wdata);
    end
    repeat (5) begin
      idle_cycle();
      if (frame_done !== 1'b0) fd_seen++;
    end
    n_cmp++;
    if (fd_seen !== 0) begin
      n_bad++;
      $display("FAIL abort_no_done: frame_done seen %0d cycles, need 0", fd_seen);
    end
    pulse_abort();
  endtask

  initial begin
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    abort    = 1'b0;
    test_reset();
    test_idle_sync();
    test_full_frame(1'b0);
    test_done_drop();
    test_gapped_frame();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
